// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register file, immediate generator and a
// handshaked ID/EX register with load-use stall, flush and write-back bypass.
module decode_stage #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            out_is_load,
  output logic            out_illegal
);

  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] r_regs [NREGS];

  logic            r_valid;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1Data;
  logic [XLEN-1:0] r_rs2Data;
  logic [XLEN-1:0] r_imm;
  logic [4:0]      r_rs1;
  logic [4:0]      r_rs2;
  logic [4:0]      r_rd;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic [6:0]      r_funct7;
  logic            r_isLoad;
  logic            r_illegal;

  logic [6:0]      w_opcode;
  logic [4:0]      w_rd;
  logic [2:0]      w_funct3;
  logic [4:0]      w_rs1;
  logic [4:0]      w_rs2;
  logic [6:0]      w_funct7;
  logic            w_known;
  logic            w_usesRs1;
  logic            w_usesRs2;
  logic            w_writesRd;
  logic [31:0]     w_imm32;
  logic [XLEN-1:0] w_imm;
  logic            w_rs1Ok;
  logic            w_rs2Ok;
  logic            w_rdOk;
  logic            w_wbOk;
  logic            w_illegal;
  logic [XLEN-1:0] w_rs1Data;
  logic [XLEN-1:0] w_rs2Data;
  logic            w_hazard;
  logic            w_accept;

  assign w_opcode = in_instr[6:0];
  assign w_rd     = in_instr[11:7];
  assign w_funct3 = in_instr[14:12];
  assign w_rs1    = in_instr[19:15];
  assign w_rs2    = in_instr[24:20];
  assign w_funct7 = in_instr[31:25];

  assign w_rs1Ok = 32'(w_rs1) < NREGS;
  assign w_rs2Ok = 32'(w_rs2) < NREGS;
  assign w_rdOk  = 32'(w_rd) < NREGS;
  assign w_wbOk  = 32'(wb_rd) < NREGS;

  // Opcode class: which source registers are read, whether rd is written, immediate format
  always_comb begin
    w_known    = 1'b1;
    w_usesRs1  = 1'b1;
    w_usesRs2  = 1'b0;
    w_writesRd = 1'b1;
    w_imm32    = '0;
    case (w_opcode)
      OP_LUI, OP_AUIPC: begin
        w_usesRs1 = 1'b0;
        w_imm32   = {in_instr[31:12], 12'b0};
      end
      OP_JAL: begin
        w_usesRs1 = 1'b0;
        w_imm32   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                     in_instr[20], in_instr[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_IMM: begin
        w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      OP_STORE: begin
        w_usesRs2  = 1'b1;
        w_writesRd = 1'b0;
        w_imm32    = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      OP_BRANCH: begin
        w_usesRs2  = 1'b1;
        w_writesRd = 1'b0;
        w_imm32    = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                      in_instr[30:25], in_instr[11:8], 1'b0};
      end
      OP_REG: begin
        w_usesRs2 = 1'b1;
      end
      OP_FENCE, OP_SYSTEM: begin
        w_known = 1'b1;
      end
      default: begin
        w_known = 1'b0;
      end
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  assign w_illegal = !w_known
                  || (w_usesRs1 && !w_rs1Ok)
                  || (w_usesRs2 && !w_rs2Ok)
                  || (w_writesRd && !w_rdOk);

  // Register reads: x0 and indices beyond NREGS read zero; optional same-cycle WB forward
  always_comb begin
    w_rs1Data = '0;
    if (w_rs1 != 5'd0 && w_rs1Ok) begin
      w_rs1Data = r_regs[w_rs1[AW-1:0]];
      if (WB_BYPASS && wb_we && wb_rd == w_rs1) begin
        w_rs1Data = wb_data;
      end
    end
  end

  always_comb begin
    w_rs2Data = '0;
    if (w_rs2 != 5'd0 && w_rs2Ok) begin
      w_rs2Data = r_regs[w_rs2[AW-1:0]];
      if (WB_BYPASS && wb_we && wb_rd == w_rs2) begin
        w_rs2Data = wb_data;
      end
    end
  end

  assign w_hazard = r_valid && r_isLoad && (r_rd != 5'd0)
                 && ((w_usesRs1 && w_rs1 == r_rd) || (w_usesRs2 && w_rs2 == r_rd));

  assign in_ready = !rst && (!r_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (wb_we && wb_rd != 5'd0 && w_wbOk) begin
      r_regs[wb_rd[AW-1:0]] <= wb_data;
    end
  end

  // ID/EX register: a load-use hazard with out_ready high falls through to the bubble branch
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid   <= 1'b0;
      r_pc      <= '0;
      r_rs1Data <= '0;
      r_rs2Data <= '0;
      r_imm     <= '0;
      r_rs1     <= '0;
      r_rs2     <= '0;
      r_rd      <= '0;
      r_opcode  <= '0;
      r_funct3  <= '0;
      r_funct7  <= '0;
      r_isLoad  <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_pc      <= in_pc;
      r_rs1Data <= w_rs1Data;
      r_rs2Data <= w_rs2Data;
      r_imm     <= w_imm;
      r_rs1     <= w_rs1;
      r_rs2     <= w_rs2;
      r_rd      <= w_rd;
      r_opcode  <= w_opcode;
      r_funct3  <= w_funct3;
      r_funct7  <= w_funct7;
      r_isLoad  <= (w_opcode == OP_LOAD);
      r_illegal <= w_illegal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid    = r_valid;
  assign out_pc       = r_pc;
  assign out_rs1_data = r_rs1Data;
  assign out_rs2_data = r_rs2Data;
  assign out_imm      = r_imm;
  assign out_rs1      = r_rs1;
  assign out_rs2      = r_rs2;
  assign out_rd       = r_rd;
  assign out_opcode   = r_opcode;
  assign out_funct3   = r_funct3;
  assign out_funct7   = r_funct7;
  assign out_is_load  = r_isLoad;
  assign out_illegal  = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (RV32I with bypass, RV32E-sized without)
// share stimulus and are compared against a behavioural model of the stage.
module tb_decode_stage;

  localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23, OPI = 7'h13;
  localparam logic [6:0] OPR = 7'h33, FENCE = 7'h0F, SYS = 7'h73;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1d;
    logic [31:0] rs2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ld;
    logic        ill;
  } payload_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic inValid, flush, wbWe, outReady;
  logic [31:0] inInstr, inPc, wbData;
  logic [4:0] wbRd;

  logic aReady, aValid, aLoad, aIll, bReady, bValid, bLoad, bIll;
  logic [31:0] aPc, aRs1d, aRs2d, aImm, bPc, bRs1d, bRs2d, bImm;
  logic [4:0] aRs1, aRs2, aRd, bRs1, bRs2, bRd;
  logic [6:0] aOpc, aF7, bOpc, bF7;
  logic [2:0] aF3, bF3;
  payload_t aPay, bPay;

  assign aPay = {aPc, aRs1d, aRs2d, aImm, aRs1, aRs2, aRd, aOpc, aF3, aF7, aLoad, aIll};
  assign bPay = {bPc, bRs1d, bRs2d, bImm, bRs1, bRs2, bRd, bOpc, bF3, bF7, bLoad, bIll};

  logic [31:0] mRegs [2][32];
  logic        mValid;
  logic        mFresh;
  payload_t    mPay [2];
  int checks = 0;
  int failures = 0;
  logic [6:0] opTable [13];

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .NREGS(32), .WB_BYPASS(1'b1)) dutA (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(aReady), .in_instr(inInstr),
    .in_pc(inPc), .flush(flush), .wb_we(wbWe), .wb_rd(wbRd), .wb_data(wbData),
    .out_valid(aValid), .out_ready(outReady), .out_pc(aPc), .out_rs1_data(aRs1d),
    .out_rs2_data(aRs2d), .out_imm(aImm), .out_rs1(aRs1), .out_rs2(aRs2), .out_rd(aRd),
    .out_opcode(aOpc), .out_funct3(aF3), .out_funct7(aF7), .out_is_load(aLoad),
    .out_illegal(aIll)
  );

  decode_stage #(.XLEN(32), .NREGS(16), .WB_BYPASS(1'b0)) dutB (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(bReady), .in_instr(inInstr),
    .in_pc(inPc), .flush(flush), .wb_we(wbWe), .wb_rd(wbRd), .wb_data(wbData),
    .out_valid(bValid), .out_ready(outReady), .out_pc(bPc), .out_rs1_data(bRs1d),
    .out_rs2_data(bRs2d), .out_imm(bImm), .out_rs1(bRs1), .out_rs2(bRs2), .out_rd(bRd),
    .out_opcode(bOpc), .out_funct3(bF3), .out_funct7(bF7), .out_is_load(bLoad),
    .out_illegal(bIll)
  );

  // Reference model: instruction classes and immediates straight from the ISA rules
  function automatic bit isKnown(logic [6:0] op);
    return op inside {LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, FENCE, SYS};
  endfunction

  function automatic bit usesRs1(logic [6:0] op);
    return !(op inside {LUI, AUIPC, JAL});
  endfunction

  function automatic bit usesRs2(logic [6:0] op);
    return op inside {OPR, ST, BR};
  endfunction

  function automatic bit writesRd(logic [6:0] op);
    return !(op inside {ST, BR});
  endfunction

  function automatic logic [31:0] immOf(logic [31:0] ins);
    case (ins[6:0])
      OPI, LD, JALR: return 32'($signed(ins[31:20]));
      ST:            return 32'($signed({ins[31:25], ins[11:7]}));
      BR:            return 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      LUI, AUIPC:    return {ins[31:12], 12'h000};
      JAL:           return 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      default:       return 32'd0;
    endcase
  endfunction

  function automatic int nregsOf(int c);
    return (c == 0) ? 32 : 16;
  endfunction

  function automatic logic [31:0] readReg(int c, logic [4:0] idx);
    if (idx == 5'd0 || int'(idx) >= nregsOf(c)) return 32'd0;
    if (c == 0 && wbWe && wbRd == idx) return wbData;
    return mRegs[c][idx];
  endfunction

  function automatic payload_t decodeModel(int c, logic [31:0] ins, logic [31:0] pc);
    payload_t p;
    int n = nregsOf(c);
    logic [6:0] op = ins[6:0];
    p.pc   = pc;
    p.rs1  = ins[19:15];
    p.rs2  = ins[24:20];
    p.rd   = ins[11:7];
    p.opc  = op;
    p.f3   = ins[14:12];
    p.f7   = ins[31:25];
    p.rs1d = readReg(c, p.rs1);
    p.rs2d = readReg(c, p.rs2);
    p.imm  = immOf(ins);
    p.ld   = (op == LD);
    p.ill  = !isKnown(op) || (usesRs1(op) && int'(p.rs1) >= n)
          || (usesRs2(op) && int'(p.rs2) >= n) || (writesRd(op) && int'(p.rd) >= n);
    return p;
  endfunction

  function automatic logic modelReady();
    logic hz;
    hz = mValid && mPay[0].ld && mPay[0].rd != 5'd0
      && ((usesRs1(inInstr[6:0]) && inInstr[19:15] == mPay[0].rd)
       || (usesRs2(inInstr[6:0]) && inInstr[24:20] == mPay[0].rd));
    return !rst && (!mValid || outReady) && !flush && !hz;
  endfunction

  task automatic modelReset();
    for (int c = 0; c < 2; c++) begin
      for (int r = 0; r < 32; r++) mRegs[c][r] = 32'd0;
      mPay[c] = '0;
    end
    mValid = 1'b0;
    mFresh = 1'b1;
  endtask

  task automatic modelEdge();
    logic rdy;
    payload_t p0, p1;
    rdy = modelReady();
    p0 = decodeModel(0, inInstr, inPc);
    p1 = decodeModel(1, inInstr, inPc);
    if (flush) begin
      mValid = 1'b0;
    end else if (inValid && rdy) begin
      mPay[0] = p0;
      mPay[1] = p1;
      mValid  = 1'b1;
      mFresh  = 1'b0;
    end else if (outReady) begin
      mValid = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      if (wbWe && wbRd != 5'd0 && int'(wbRd) < nregsOf(c)) mRegs[c][wbRd] = wbData;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkPay(input string tag, input payload_t obs, input payload_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic expReady;
    expReady = modelReady();
    chk("A_in_ready", 32'(aReady), 32'(expReady));
    chk("B_in_ready", 32'(bReady), 32'(expReady));
    chk("A_out_valid", 32'(aValid), 32'(mValid));
    chk("B_out_valid", 32'(bValid), 32'(mValid));
    if (mValid || mFresh) begin
      chkPay("A_payload", aPay, mPay[0]);
      chkPay("B_payload", bPay, mPay[1]);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                               input logic ordy, input logic fl, input logic we,
                               input logic [4:0] rd, input logic [31:0] d);
    inValid  = v;
    inInstr  = ins;
    inPc     = pc;
    outReady = ordy;
    flush    = fl;
    wbWe     = we;
    wbRd     = rd;
    wbData   = d;
  endtask

  task automatic tick();
    #1 checkOutput();
    @(posedge clk);
    if (rst) modelReset();
    else modelEdge();
    @(negedge clk);
  endtask

  task automatic midReset();
    #2 rst = 1'b1;
    #1 modelReset();
    checkOutput();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  rdSel;
    opTable = '{LUI, AUIPC, JAL, JALR, BR, LD, ST, OPI, OPR, FENCE, SYS, 7'h7F, 7'h00};
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
    modelReset();
    @(negedge clk);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 32'h00510093 + 32'(i << 20), 32'(i * 4), 1'b1, 1'b0,
                    1'b1, 5'(i + 1), 32'(i * 3 + 1));
      tick();
    end
    midReset();

    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'd7);
    tick();
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'd9);
    tick();
    applyStimulus(1'b1, 32'h003100B3, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1;
    chk("add_valid", 32'(aValid), 32'd1);
    chk("add_rs1_data", aRs1d, 32'd7);
    chk("add_rs2_data", aRs2d, 32'd9);
    chk("add_rd", 32'(aRd), 32'd1);
    chk("add_funct", 32'({aF3, aF7}), 32'd0);
    chk("add_imm", aImm, 32'd0);

    applyStimulus(1'b1, 32'h00510093, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("addi_imm", aImm, 32'd5);
    applyStimulus(1'b1, 32'h00208263, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("beq_imm", aImm, 32'd4);
    applyStimulus(1'b1, 32'hFFFFF0B7, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("lui_imm", aImm, 32'hFFFFF000);
    applyStimulus(1'b1, 32'hFFDFF0EF, 32'h110, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("jal_imm", aImm, 32'hFFFFFFFC);

    applyStimulus(1'b1, 32'h0002A083, 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h00208233, 32'h118, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 chk("loaduse_stall", 32'(aReady), 32'd0);
    tick();
    #1 chk("loaduse_bubble", 32'(aValid), 32'd0);
    chk("loaduse_ready_after", 32'(aReady), 32'd1);
    tick();
    #1 chk("loaduse_add_rd", 32'(aRd), 32'd4);
    applyStimulus(1'b1, 32'h0002A003, 32'h11C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h00200233, 32'h120, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    #1 chk("load_x0_nostall", 32'(aReady), 32'd1);
    tick();

    applyStimulus(1'b1, 32'h00510093, 32'h200, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h003100B3, 32'h204, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 chk("hold_pc", aPc, 32'h200);
      chk("hold_ready", 32'(aReady), 32'd0);
      tick();
    end
    applyStimulus(1'b1, 32'h003100B3, 32'h204, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("hold_next_pc", aPc, 32'h204);
    applyStimulus(1'b0, 32'd0, 32'h0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("hold_no_dup", 32'(aValid), 32'd0);

    applyStimulus(1'b1, 32'h00510093, 32'h208, 1'b1, 1'b0, 1'b1, 5'd2, 32'hDEADBEEF);
    tick();
    #1 chk("bypass_on", aRs1d, 32'hDEADBEEF);
    chk("bypass_off", bRs1d, 32'd7);
    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h1234);
    tick();
    applyStimulus(1'b1, 32'h000000B3, 32'h20C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("x0_reads_zero", aRs1d, 32'd0);

    applyStimulus(1'b1, 32'h00510093, 32'h300, 1'b0, 1'b1, 1'b1, 5'd5, 32'h55);
    #1 chk("flush_ready", 32'(aReady), 32'd0);
    tick();
    #1 chk("flush_valid", 32'(aValid), 32'd0);
    applyStimulus(1'b1, 32'h000280B3, 32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("flush_wb_commit", aRs1d, 32'h55);
    applyStimulus(1'b1, 32'h001A0093, 32'h308, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("x20_legal_rv32i", 32'(aIll), 32'd0);
    chk("x20_illegal_rv32e", 32'(bIll), 32'd1);
    applyStimulus(1'b1, 32'h0000007F, 32'h30C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("unknown_illegal", 32'(aIll), 32'd1);
    chk("unknown_imm", aImm, 32'd0);
    applyStimulus(1'b1, 32'h00510093, 32'h310, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    #1 chk("illegal_not_sticky", 32'(aIll), 32'd0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) midReset();
      ins = $urandom;
      ins[6:0] = opTable[$urandom_range(0, 12)];
      if ($urandom_range(0, 1) == 1) begin
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
      end
      rdSel = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom);
      applyStimulus(1'($urandom_range(0, 99) < 75), ins, $urandom & 32'hFFFFFFFC,
                    1'($urandom_range(0, 99) < 70), 1'($urandom_range(0, 99) < 5),
                    1'($urandom_range(0, 1)), rdSel, $urandom);
      tick();
    end

    applyStimulus(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised, pipelined instruction-decode stage for the RV32I core. It sits between the fetch-stage IF/ID register and the execute stage and contains the register file and immediate generator. It also holds a registered ID/EX output with valid/ready handshake, load-use stall detection, flush, and optional write-back bypass. It supersedes the flat combinational ID block.

## Interface
- XLEN, 32: datapath width (32 or 64); immediates sign-extend to XLEN.
- NREGS, 32: architectural registers (32 = RV32I, 16 = RV32E); x0 always reads 0.
- WB_BYPASS, 1: 1 = same-cycle write-back data forwarded to register reads.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- flush  in  1  squash the instruction held in the ID/EX register.
- wb_we  in  1  register-file write enable.
- wb_rd  in  5  write register index.
- wb_data  in  XLEN  write data.
- out_valid  out  1  ID/EX register holds a valid decoded instruction.
- out_ready  in  1  execute consumes it.
- out_pc, out_rs1_data, out_rs2_data, out_imm  out  XLEN  decoded payload.
- out_rs1, out_rs2, out_rd  out  5  register indices.
- out_opcode  out  7.
- out_funct3  out  3.
- out_funct7  out  7.
- out_is_load  out  1  opcode 0000011.
- out_illegal  out  1  unknown opcode, or register index >= NREGS.

## Operation
- Accept occurs when in_valid && in_ready; fields are decoded, the register file is read, and the ID/EX register loads on that edge.
- in_ready = (!out_valid || out_ready) && !hazard && !flush.
- hazard = out_valid && out_is_load && out_rd != 0 && ((uses_rs1 && rs1 == out_rd) || (uses_rs2 && rs2 == out_rd)).
- uses_rs1: every opcode except LUI 0110111, AUIPC 0010111, JAL 1101111.
- uses_rs2: R 0110011, S 0100011, B 1100011.
- Hazard with out_ready=1: the load leaves, the ID/EX register loads a bubble (out_valid=0), and the instruction is accepted next cycle.
- Immediates:
  - I (0010011, 0000011, 1100111): instr[31:20] sign-extended.
  - S: {instr[31:25], instr[11:7]}.
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U (LUI, AUIPC): {instr[31:12], 12'b0} sign-extended.
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - R and unknown opcodes: 0.
- Register file: NREGS x XLEN, written on the rising edge when wb_we && wb_rd != 0 && wb_rd < NREGS. Writes to x0 or out-of-range indices are ignored.
- WB_BYPASS=1: a read of index r with wb_we && wb_rd == r && r != 0 returns wb_data combinationally.
- WB_BYPASS=0: the same read returns the old value.
- Unknown opcode: out_illegal=1, imm=0. The instruction still flows; the flag is not sticky.
- flush: on the next edge out_valid=0. The instruction at in_* is not accepted that cycle. A simultaneous write-back still commits.

## Timing
- Latency 1 cycle: accept at edge N, so out_valid=1 in cycle N+1.
- Holding: while out_valid && !out_ready, all out_* stay stable and in_ready=0.
- Throughput: one instruction per cycle with no hazard and out_ready held at 1.
- Load-use costs exactly one bubble cycle.
- Reset (async, mid-operation included): out_valid=0, every out_* field 0, all registers 0, in_ready=1 once rst deasserts (in_ready=0 while rst=1).
- Priority: rst > flush > hazard > normal accept.

## Test plan
- Reset mid-stream, then write x2=7 and x3=9, then ADD 0x003100B3 -> out_valid next cycle; rs1_data=7, rs2_data=9, rd=1, funct3=0, funct7=0, imm=0.
- ADDI 0x00510093 and BEQ 0x00208263 -> imm=5 and imm=4 respectively. LUI 0xFFFFF0B7 -> imm=0xFFFFF000. JAL 0xFFDFF0EF -> imm=-4 (0xFFFFFFFC).
- LW x1 held in ID/EX while ADD x4,x1,x2 is presented with out_ready=1 -> in_ready=0 for 1 cycle, one bubble, ADD accepted next cycle. LW with rd=0 -> no stall.
- out_ready=0 for 3 cycles with in_valid=1 -> out_* unchanged, in_ready=0, no instruction lost or duplicated.
- wb_we=1, wb_rd=2, wb_data=0xDEADBEEF in the same cycle as an accept reading x2: WB_BYPASS=1 gives rs1_data=0xDEADBEEF, WB_BYPASS=0 gives the old value. A write to x0 leaves x0 reading 0.
- flush while valid, plus NREGS=16 reading x20 -> out_valid drops the next cycle. The x20 instruction flows with out_illegal=1. Opcode 0x7F gives out_illegal=1 and imm=0.
